// File: rtl/control_unit_stack.sv
// control_unit_stack
//   SimpleCPU controller: program counter, instruction register and a Moore
//   FSM, extended with an instruction-memory ready handshake, JMP, CALL/RET
//   through an internal return-address stack, HALT and a fault report.
//
// Parameters
//   PC_W         program counter width (>= 12)
//   STACK_DEPTH  return-address stack entries (>= 1)
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   inst, inst_valid     instruction word and its valid qualifier
//   RF_Rp_zero           register-file port P data is zero (JMPZ condition)
//   progcntr, fetch      instruction-memory address and read request
//   D_addr, D_rd, D_wr   data-memory address and strobes
//   RF_W_data            LOADC constant
//   RF_s1, RF_s0         RF write mux: 00 ALU, 01 D memory, 10 constant
//   RF_W_addr, RF_W_wr   RF write port
//   RF_Rp_addr, RF_Rp_rd RF read port P
//   RF_Rq_addr, RF_Rq_rd RF read port Q
//   alu_s1, alu_s0       ALU op: 00 pass Rp, 01 Rp+Rq, 10 Rp-Rq
//   halted               FSM is in HALT
//   fault                00 none, 01 illegal opcode, 10 overflow, 11 underflow
module control_unit_stack #(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     inst,
  input  logic            inst_valid,
  input  logic            RF_Rp_zero,
  output logic [PC_W-1:0] progcntr,
  output logic            fetch,
  output logic [7:0]      D_addr,
  output logic            D_rd,
  output logic            D_wr,
  output logic [7:0]      RF_W_data,
  output logic            RF_s1,
  output logic            RF_s0,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_wr,
  output logic [3:0]      RF_Rp_addr,
  output logic            RF_Rp_rd,
  output logic [3:0]      RF_Rq_addr,
  output logic            RF_Rq_rd,
  output logic            alu_s1,
  output logic            alu_s0,
  output logic            halted,
  output logic [1:0]      fault
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD, S_SUB, S_LOADC,
    S_JMPZ, S_JMPZ_TAKE, S_JMP, S_CALL, S_RET, S_HALT
  } state_t;

  // Stack pointer counts occupancy 0..STACK_DEPTH. The storage array is
  // rounded up to a power of two so that the pointer indexes it exactly.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SP_W;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     ir_reg, ir_next;
  logic [SP_W-1:0] sp_reg, sp_next;
  logic [1:0]      fault_reg, fault_next;
  logic            push_en;

  logic [PC_W-1:0] stack_mem [SLOTS];
  logic [PC_W-1:0] stack_top;
  logic            stack_full;
  logic            stack_empty;

  // By the time a branch executes, pc_reg already points one past the
  // branch, so the target is pc_reg + offset - 1.
  logic [PC_W-1:0] off8, off12;
  logic [PC_W-1:0] jmpz_target, long_target;

  assign off8        = PC_W'($signed(ir_reg[7:0]));
  assign off12       = PC_W'($signed(ir_reg[11:0]));
  assign jmpz_target = pc_reg + off8 - PC_W'(1);
  assign long_target = pc_reg + off12 - PC_W'(1);

  assign stack_top   = stack_mem[sp_reg - SP_W'(1)];
  assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_reg == '0);

  // State and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_INIT;
      pc_reg    <= '0;
      ir_reg    <= '0;
      sp_reg    <= '0;
      fault_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      sp_reg    <= sp_next;
      fault_reg <= fault_next;
    end
  end

  // Return-address storage; contents are meaningless beyond sp_reg, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_reg] <= pc_reg;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    sp_next    = sp_reg;
    fault_next = fault_reg;
    push_en    = 1'b0;
    case (state_reg)
      S_INIT: state_next = S_FETCH;
      S_FETCH: begin
        if (inst_valid) begin
          ir_next    = inst;
          pc_next    = pc_reg + PC_W'(1);
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_reg[15:12])
          4'h0: state_next = S_LOAD;
          4'h1: state_next = S_STORE;
          4'h2: state_next = S_ADD;
          4'h3: state_next = S_LOADC;
          4'h4: state_next = S_SUB;
          4'h5: state_next = S_JMPZ;
          4'h6: state_next = S_JMP;
          4'h7: state_next = S_CALL;
          4'h8: state_next = S_RET;
          4'hF: state_next = S_HALT;
          default: begin
            fault_next = 2'b01;
            state_next = S_HALT;
          end
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_LOADC: state_next = S_FETCH;
      S_JMPZ: state_next = RF_Rp_zero ? S_JMPZ_TAKE : S_FETCH;
      S_JMPZ_TAKE: begin
        pc_next    = jmpz_target;
        state_next = S_FETCH;
      end
      S_JMP: begin
        pc_next    = long_target;
        state_next = S_FETCH;
      end
      S_CALL: begin
        if (stack_full) begin
          fault_next = 2'b10;
          state_next = S_HALT;
        end else begin
          push_en    = 1'b1;
          sp_next    = sp_reg + SP_W'(1);
          pc_next    = long_target;
          state_next = S_FETCH;
        end
      end
      S_RET: begin
        if (stack_empty) begin
          fault_next = 2'b11;
          state_next = S_HALT;
        end else begin
          pc_next    = stack_top;
          sp_next    = sp_reg - SP_W'(1);
          state_next = S_FETCH;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_INIT;
    endcase
  end

  // Moore outputs from state and IR
  always_comb begin
    fetch      = 1'b0;
    D_addr     = 8'h00;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_W_data  = 8'h00;
    RF_s1      = 1'b0;
    RF_s0      = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_wr    = 1'b0;
    RF_Rp_addr = 4'h0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_addr = 4'h0;
    RF_Rq_rd   = 1'b0;
    alu_s1     = 1'b0;
    alu_s0     = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: fetch = 1'b1;
      S_LOAD: begin
        D_addr    = ir_reg[7:0];
        D_rd      = 1'b1;
        RF_s0     = 1'b1;
        RF_W_addr = ir_reg[11:8];
        RF_W_wr   = 1'b1;
      end
      S_STORE: begin
        D_addr     = ir_reg[7:0];
        D_wr       = 1'b1;
        RF_Rp_addr = ir_reg[11:8];
        RF_Rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Rp_addr = ir_reg[7:4];
        RF_Rp_rd   = 1'b1;
        RF_Rq_addr = ir_reg[3:0];
        RF_Rq_rd   = 1'b1;
        RF_W_addr  = ir_reg[11:8];
        RF_W_wr    = 1'b1;
        alu_s0     = (state_reg == S_ADD);
        alu_s1     = (state_reg == S_SUB);
      end
      S_LOADC: begin
        RF_W_data = ir_reg[7:0];
        RF_s1     = 1'b1;
        RF_W_addr = ir_reg[11:8];
        RF_W_wr   = 1'b1;
      end
      S_JMPZ: begin
        RF_Rp_addr = ir_reg[11:8];
        RF_Rp_rd   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign progcntr = pc_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_control_unit_stack.sv
// Testbench for control_unit_stack (PC_W = 16, STACK_DEPTH = 2).
// Each test pushes the expected output vector for every cycle it drives onto
// a scoreboard queue; the driver records one DUT sample per cycle, and the
// test then pops both queues and compares them in order.
module tb_control_unit_stack;
  localparam int PC_W  = 16;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     inst;
  logic            inst_valid;
  logic            RF_Rp_zero;
  logic [PC_W-1:0] progcntr;
  logic            fetch, D_rd, D_wr, RF_s1, RF_s0, RF_W_wr, RF_Rp_rd, RF_Rq_rd;
  logic            alu_s1, alu_s0, halted;
  logic [7:0]      D_addr, RF_W_data;
  logic [3:0]      RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic [1:0]      fault;

  always #5 clk = ~clk;

  control_unit_stack #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .RF_Rp_zero(RF_Rp_zero), .progcntr(progcntr), .fetch(fetch),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_W_data(RF_W_data),
    .RF_s1(RF_s1), .RF_s0(RF_s0), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
    .RF_Rp_addr(RF_Rp_addr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_addr(RF_Rq_addr),
    .RF_Rq_rd(RF_Rq_rd), .alu_s1(alu_s1), .alu_s0(alu_s0),
    .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        fetch;
    logic [7:0]  d_addr;
    logic        d_rd, d_wr;
    logic [7:0]  w_data;
    logic        s1, s0;
    logic [3:0]  w_addr;
    logic        w_wr;
    logic [3:0]  p_addr;
    logic        p_rd;
    logic [3:0]  q_addr;
    logic        q_rd;
    logic        a1, a0;
    logic        halted;
    logic [1:0]  fault;
  } out_t;

  typedef struct {
    string name;
    out_t  v;
  } exp_t;

  exp_t exp_q[$];
  out_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t sample();
    out_t s;
    s.pc = progcntr; s.fetch = fetch; s.d_addr = D_addr; s.d_rd = D_rd;
    s.d_wr = D_wr; s.w_data = RF_W_data; s.s1 = RF_s1; s.s0 = RF_s0;
    s.w_addr = RF_W_addr; s.w_wr = RF_W_wr; s.p_addr = RF_Rp_addr;
    s.p_rd = RF_Rp_rd; s.q_addr = RF_Rq_addr; s.q_rd = RF_Rq_rd;
    s.a1 = alu_s1; s.a0 = alu_s0; s.halted = halted; s.fault = fault;
    return s;
  endfunction

  // Reference model of the per-state outputs
  function automatic out_t m_idle(input logic [15:0] pc);
    out_t e = '0;
    e.pc = pc;
    return e;
  endfunction

  function automatic out_t m_fetch(input logic [15:0] pc);
    out_t e = m_idle(pc);
    e.fetch = 1'b1;
    return e;
  endfunction

  function automatic out_t m_halt(input logic [15:0] pc, input logic [1:0] f);
    out_t e = m_idle(pc);
    e.halted = 1'b1;
    e.fault  = f;
    return e;
  endfunction

  function automatic out_t m_exec(input logic [15:0] ir, input logic [15:0] pc);
    out_t e = m_idle(pc);
    case (ir[15:12])
      4'h0: begin e.d_addr = ir[7:0]; e.d_rd = 1; e.s0 = 1; e.w_addr = ir[11:8]; e.w_wr = 1; end
      4'h1: begin e.d_addr = ir[7:0]; e.d_wr = 1; e.p_addr = ir[11:8]; e.p_rd = 1; end
      4'h2, 4'h4: begin
        e.p_addr = ir[7:4]; e.p_rd = 1; e.q_addr = ir[3:0]; e.q_rd = 1;
        e.w_addr = ir[11:8]; e.w_wr = 1;
        e.a0 = (ir[15:12] == 4'h2); e.a1 = (ir[15:12] == 4'h4);
      end
      4'h3: begin e.w_data = ir[7:0]; e.s1 = 1; e.w_addr = ir[11:8]; e.w_wr = 1; end
      4'h5: begin e.p_addr = ir[11:8]; e.p_rd = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record();
    obs_q.push_back(sample());
  endtask

  task automatic expect_v(input string name, input out_t v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_valid = 1'b0; inst = 16'h0000; RF_Rp_zero = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Starting in FETCH: hold inst_valid low for 'waits' cycles, present instr,
  // then sample DECODE and exec_cycles further cycles. One sample per cycle.
  task automatic issue(input logic [15:0] instr, input int waits,
                       input logic zero, input int exec_cycles);
    for (int w = 0; w < waits; w++) begin
      inst_valid = 1'b0; inst = 16'($urandom); record(); step();
    end
    inst = instr; inst_valid = 1'b1; record(); step();
    inst_valid = 1'b0; inst = 16'($urandom); RF_Rp_zero = zero; record(); step();
    for (int c = 0; c < exec_cycles; c++) begin
      record(); step();
    end
  endtask

  // Expectations for a plain instruction fetched at pc, no wait states
  task automatic expect_plain(input string name, input logic [15:0] instr,
                              input logic [15:0] pc);
    expect_v({name, "_fetch"}, m_fetch(pc));
    expect_v({name, "_decode"}, m_idle(pc + 16'd1));
    expect_v({name, "_exec"}, m_exec(instr, pc + 16'd1));
  endtask

  task automatic test_reset();
    exp_t e; out_t o;
    rst = 1'b1; inst_valid = 1'b1; inst = 16'h3105; RF_Rp_zero = 1'b1;
    #1;
    expect_v("reset_async", '0); record();
    step();
    expect_v("reset_held", '0); record();
    rst = 1'b0; inst_valid = 1'b0;
    expect_v("reset_init", '0); record();
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_loadc();
    exp_t e; out_t o;
    expect_plain("t1", 16'h3105, 16'h0000);
    issue(16'h3105, 0, 1'b0, 1);
    expect_v("t1_next", m_fetch(16'h0001)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e; out_t o;
    for (int w = 0; w < 3; w++) expect_v("t2_wait", m_fetch(16'h0001));
    expect_plain("t2", 16'h3A7E, 16'h0001);
    issue(16'h3A7E, 3, 1'b0, 1);
    expect_v("t2_next", m_fetch(16'h0002)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; out_t o;
    logic [15:0] prog [5] = '{16'h0A3C, 16'h1B7F, 16'h2123, 16'h4456, 16'h3FFF};
    logic [15:0] pc = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      expect_plain($sformatf("b2b%0d", i), prog[i], pc);
      issue(prog[i], 0, 1'b0, 1);
      pc = pc + 16'd1;
    end
    expect_v("b2b_next", m_fetch(pc)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_jmpz();
    exp_t e; out_t o;
    do_reset();
    expect_plain("t3_jmp", 16'h6004, 16'h0000);
    issue(16'h6004, 0, 1'b0, 1);
    expect_plain("t3_taken", 16'h52FE, 16'h0004);
    expect_v("t3_take_cycle", m_idle(16'h0005));
    issue(16'h52FE, 0, 1'b1, 2);
    expect_plain("t3_jmp2", 16'h6002, 16'h0002);
    issue(16'h6002, 0, 1'b0, 1);
    expect_plain("t3_not_taken", 16'h52FE, 16'h0004);
    issue(16'h52FE, 0, 1'b0, 1);
    expect_v("t3_next", m_fetch(16'h0005)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_call_ret();
    exp_t e; out_t o;
    logic [15:0] prog [6] = '{16'h6010, 16'h7020, 16'h8000, 16'h7100, 16'h7F00, 16'h8000};
    logic [15:0] addr [6] = '{16'h0000, 16'h0010, 16'h0030, 16'h0011, 16'h0111, 16'h0011};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      expect_plain($sformatf("t4_%0d", i), prog[i], addr[i]);
      issue(prog[i], 0, 1'b0, 1);
    end
    // inner RET returns to 0x0112, outer RET to 0x0012
    expect_plain("t4_ret_outer", 16'h8000, 16'h0112);
    issue(16'h8000, 0, 1'b0, 1);
    expect_v("t4_next", m_fetch(16'h0012)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_jmp_wrap();
    exp_t e; out_t o;
    do_reset();
    expect_plain("wrap_jmp", 16'h6FFF, 16'h0000);
    issue(16'h6FFF, 0, 1'b0, 1);
    expect_plain("wrap_loadc", 16'h3201, 16'hFFFF);
    issue(16'h3201, 0, 1'b0, 1);
    expect_v("wrap_next", m_fetch(16'h0000)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_stack_faults();
    exp_t e; out_t o;
    do_reset();
    expect_plain("t5_call0", 16'h7010, 16'h0000);
    issue(16'h7010, 0, 1'b0, 1);
    expect_plain("t5_call1", 16'h7010, 16'h0010);
    issue(16'h7010, 0, 1'b0, 1);
    expect_plain("t5_call2", 16'h7010, 16'h0020);
    expect_v("t5_overflow", m_halt(16'h0021, 2'b10));
    expect_v("t5_overflow_hold", m_halt(16'h0021, 2'b10));
    issue(16'h7010, 0, 1'b0, 3);
    inst = 16'h3105; inst_valid = 1'b1; step();
    expect_v("t5_sticky", m_halt(16'h0021, 2'b10)); record();
    do_reset();
    expect_plain("t5_ret", 16'h8000, 16'h0000);
    expect_v("t5_underflow", m_halt(16'h0001, 2'b11));
    expect_v("t5_underflow_hold", m_halt(16'h0001, 2'b11));
    issue(16'h8000, 0, 1'b0, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_illegal_halt();
    exp_t e; out_t o;
    logic [15:0] ops [3] = '{16'h9000, 16'hE123, 16'hF000};
    logic [1:0]  flt [3] = '{2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      expect_v($sformatf("t6_fetch%0d", i), m_fetch(16'h0000));
      expect_v($sformatf("t6_decode%0d", i), m_idle(16'h0001));
      expect_v($sformatf("t6_halt%0d", i), m_halt(16'h0001, flt[i]));
      expect_v($sformatf("t6_hold%0d", i), m_halt(16'h0001, flt[i]));
      issue(ops[i], 0, 1'b0, 2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e; out_t o;
    do_reset();
    inst = 16'h3105; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    expect_v("t6_decode_before_rst", m_idle(16'h0001)); record();
    #2 rst = 1'b1;
    #1;
    expect_v("t6_async_rst", '0); record();
    step();
    rst = 1'b0;
    step();
    expect_v("t6_restart", m_fetch(16'h0000)); record();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no sample, required %h", e.name, e.v); end
      else begin o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got pc=%h vec=%h required pc=%h vec=%h", e.name, o.pc, o, e.v.pc, e.v); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; inst = 16'h0000; inst_valid = 1'b0; RF_Rp_zero = 1'b0;
    test_reset();
    test_loadc();
    test_wait_states();
    test_back_to_back();
    test_jmpz();
    test_call_ret();
    test_jmp_wrap();
    test_stack_faults();
    test_illegal_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
